// File: rtl/input_mem_pkg.sv
// Shared widths, lane/address types and the row-count clamp for the input activation buffer.
package input_mem_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic logic [31:0] clamp_rows(input logic [31:0] n, input logic [31:0] lim);
        return (n > lim) ? lim : n;
    endfunction
endpackage

// File: rtl/input_mem_lane.sv
// One lane of the input buffer: DEPTH x DATA_WIDTH RAM, synchronous write, registered read.
module input_mem_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Same-address read/write in one cycle returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/input_mem_buffer.sv
// Input activation buffer: per-lane RAMs plus burst write / wrapping read controller.
// Define INPUT_MEM_SKEW_EN to delay lane j's read by j cycles (diagonal wavefront).
module input_mem_buffer #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = input_mem_pkg::DATA_WIDTH,
    parameter int ACCUM_ROW  = 128,
    parameter int ADDR_WIDTH = input_mem_pkg::ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_in,
    input  logic                          rd_en_in,
    input  logic [31:0]                   num_row,
    input  logic [SYS_ROW*DATA_WIDTH-1:0] wr_data,
    output logic [SYS_ROW*DATA_WIDTH-1:0] rd_data,
    output logic [SYS_ROW-1:0]            rd_valid,
    output logic                          wr_done
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int MW = (ACCUM_ROW > 1) ? $clog2(ACCUM_ROW) : 1;

    logic                  wr_en_q, wr_rise, wr_fire, rd_fire;
    logic [CW-1:0]         nrow_q, nrow_eff, wr_ptr, wptr_eff, wptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;

    // The rising-edge cycle already writes row 0 using the freshly clamped count.
    always_comb begin
        wr_rise    = wr_en_in & ~wr_en_q;
        nrow_eff   = wr_rise ? CW'(input_mem_pkg::clamp_rows(num_row, 32'(ACCUM_ROW))) : nrow_q;
        wptr_eff   = wr_rise ? '0 : wr_ptr;
        wr_fire    = wr_en_in && (wptr_eff < nrow_eff);
        wptr_nxt   = wptr_eff + CW'(wr_fire);
        rd_fire    = rd_en_in && (nrow_q != '0);
        rd_ptr_nxt = rd_ptr;
        if (wr_rise)
            rd_ptr_nxt = '0;
        else if (rd_fire)
            rd_ptr_nxt = (CW'(rd_ptr) + CW'(1) == nrow_q) ? '0 : rd_ptr + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            nrow_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_en_q <= wr_en_in;
            nrow_q  <= nrow_eff;
            wr_ptr  <= wptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            wr_done <= (wr_done & ~wr_rise) | (wr_en_in & (wptr_nxt == nrow_eff));
        end
    end

`ifdef INPUT_MEM_SKEW_EN
    // One shared delay line; lane j taps stage j-1.
    logic [SYS_ROW-2:0]         vld_pipe;
    logic [SYS_ROW-2:0][MW-1:0] addr_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_fire;
            addr_pipe[0] <= rd_ptr[MW-1:0];
            for (int k = 1; k < SYS_ROW-1; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
            end
        end
    end
`endif

    for (genvar j = 0; j < SYS_ROW; j++) begin : g_lane
        logic          lane_en;
        logic [MW-1:0] lane_addr;
`ifdef INPUT_MEM_SKEW_EN
        if (j == 0) begin : g_tap0
            assign lane_en   = rd_fire;
            assign lane_addr = rd_ptr[MW-1:0];
        end else begin : g_tap
            assign lane_en   = vld_pipe[j-1];
            assign lane_addr = addr_pipe[j-1];
        end
`else
        assign lane_en   = rd_fire;
        assign lane_addr = rd_ptr[MW-1:0];
`endif
        input_mem_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (ACCUM_ROW),
            .ADDR_WIDTH(MW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire),
            .wr_addr (wptr_eff[MW-1:0]),
            .wr_data (wr_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en   (lane_en),
            .rd_addr (lane_addr),
            .rd_data (rd_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid(rd_valid[j])
        );
    end
endmodule

// File: tb/tb_input_mem_buffer.sv
// Scoreboard bench for input_mem_buffer: driver feeds a row-level model, monitor checks outputs.
module tb_input_mem_buffer;
    localparam int SYS_ROW    = 16;
    localparam int DATA_WIDTH = 16;
    localparam int ACCUM_ROW  = 128;
    localparam int VW         = SYS_ROW*DATA_WIDTH;
`ifdef INPUT_MEM_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, wr_en_in = 1'b0, rd_en_in = 1'b0;
    logic [31:0]   num_row = '0;
    logic [VW-1:0] wr_data = '0, rd_data;
    logic [SYS_ROW-1:0] rd_valid;
    logic          wr_done;

    int tests = 0, fails = 0, cyc = 0;

    input_mem_buffer #(.SYS_ROW(SYS_ROW), .DATA_WIDTH(DATA_WIDTH), .ACCUM_ROW(ACCUM_ROW), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en_in(wr_en_in), .rd_en_in(rd_en_in), .num_row(num_row),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DATA_WIDTH-1:0] d; int at; } exp_t;
    typedef struct { logic v; int at; } done_t;
    exp_t  exp_q [SYS_ROW][$];
    done_t done_q[$];
    exp_t  mon_e;
    done_t mon_d;
    logic [DATA_WIDTH-1:0] last_d [SYS_ROW];

    // Reference model: a row table plus burst bookkeeping.
    logic [DATA_WIDTH-1:0] ref_mem [ACCUM_ROW][SYS_ROW];
    int m_nrow = 0, m_wptr = 0, m_rptr = 0;
    bit m_done = 0, m_prev_we = 0;

    function automatic logic [VW-1:0] rnd_row();
        logic [VW-1:0] r;
        for (int j = 0; j < SYS_ROW; j++) r[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        return r;
    endfunction

    task automatic step(input bit we, input bit re, input int n, input logic [VW-1:0] data);
        @(posedge clk); #1;
        wr_en_in = we; rd_en_in = re; num_row = n; wr_data = data;
        if (re && m_nrow > 0) begin
            for (int j = 0; j < SYS_ROW; j++)
                exp_q[j].push_back('{ref_mem[m_rptr][j], cyc + 1 + (SKEW ? j : 0)});
            m_rptr = (m_rptr + 1) % m_nrow;
        end
        if (we && !m_prev_we) begin
            m_nrow = (n > ACCUM_ROW) ? ACCUM_ROW : n;
            m_wptr = 0; m_done = 0; m_rptr = 0;
        end
        if (we && m_wptr < m_nrow) begin
            for (int j = 0; j < SYS_ROW; j++) ref_mem[m_wptr][j] = data[j*DATA_WIDTH +: DATA_WIDTH];
            m_wptr++;
        end
        if (we && m_wptr == m_nrow) m_done = 1;
        m_prev_we = we;
        done_q.push_back('{m_done, cyc + 1});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, '0);
    endtask

    task automatic check1(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < SYS_ROW; j++) begin
                if (rd_valid[j]) begin
                    tests++;
                    if (exp_q[j].size() == 0) begin
                        fails++;
                        $display("FAIL lane%0d unexpected rd_valid at cyc %0d", j, cyc);
                    end else begin
                        mon_e = exp_q[j].pop_front();
                        if (rd_data[j*DATA_WIDTH +: DATA_WIDTH] !== mon_e.d || mon_e.at != cyc) begin
                            fails++;
                            $display("FAIL lane%0d rd_data got %h@%0d want %h@%0d", j,
                                     rd_data[j*DATA_WIDTH +: DATA_WIDTH], cyc, mon_e.d, mon_e.at);
                        end
                    end
                    last_d[j] = rd_data[j*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    if (exp_q[j].size() != 0 && exp_q[j][0].at <= cyc) begin
                        tests++; fails++;
                        $display("FAIL lane%0d missing rd_valid at cyc %0d want %h", j, cyc, exp_q[j][0].d);
                        void'(exp_q[j].pop_front());
                    end
                    tests++;
                    if (rd_data[j*DATA_WIDTH +: DATA_WIDTH] !== last_d[j]) begin
                        fails++;
                        $display("FAIL lane%0d hold got %h want %h", j, rd_data[j*DATA_WIDTH +: DATA_WIDTH], last_d[j]);
                    end
                end
            end
            while (done_q.size() != 0 && done_q[0].at <= cyc) begin
                mon_d = done_q.pop_front();
                tests++;
                if (wr_done !== mon_d.v) begin
                    fails++;
                    $display("FAIL wr_done at cyc %0d got %b want %b", cyc, wr_done, mon_d.v);
                end
            end
        end
    end

    initial begin
        for (int j = 0; j < SYS_ROW; j++) last_d[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("reset rd_valid", VW'(rd_valid), '0);
        check1("reset rd_data", rd_data, '0);
        check1("reset wr_done", VW'(wr_done), '0);
        rst = 1'b0;

        // 8-row burst, lane data = row index, then two passes of readback
        for (int i = 0; i < 8; i++) step(1, 0, 8, {SYS_ROW{DATA_WIDTH'(i)}});
        idle(2);
        for (int i = 0; i < 16; i++) step(0, 1, 8, '0);
        idle(3);

        // num_row beyond depth clamps to ACCUM_ROW, readback wraps 127 -> 0
        for (int i = 0; i < ACCUM_ROW + 2; i++) step(1, 0, 300, rnd_row());
        idle(1);
        for (int i = 0; i < ACCUM_ROW + 10; i++) step(0, 1, 300, '0);
        idle(3);

        // burst interrupted after 3 rows, then restarted from address 0
        for (int i = 0; i < 3; i++) step(1, 0, 8, rnd_row());
        idle(5);
        for (int i = 0; i < 8; i++) step(1, 0, 8, rnd_row());
        idle(1);
        for (int i = 0; i < 10; i++) step(0, 1, 8, '0);
        idle(2);

        // zero-row burst: done at once, reads never fire
        step(1, 0, 0, rnd_row());
        step(1, 0, 0, rnd_row());
        idle(1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
        idle(2);

        // random bursts with overlapping reads
        for (int it = 0; it < 8; it++) begin
            int n, len;
            n   = $urandom_range(1, 24);
            len = $urandom_range(0, n + 4);
            for (int i = 0; i < len; i++) step(1, $urandom_range(0, 1) == 1, n, rnd_row());
            step(0, 0, n, '0);
            for (int i = 0; i < $urandom_range(5, 40); i++) step(0, $urandom_range(0, 3) != 0, n, '0);
        end
        idle(SYS_ROW + 2);

        // reset asserted in the middle of a read stream
        for (int i = 0; i < 8; i++) step(1, 0, 8, rnd_row());
        idle(1);
        for (int i = 0; i < 5; i++) step(0, 1, 8, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < SYS_ROW; j++) begin exp_q[j].delete(); last_d[j] = '0; end
        done_q.delete();
        m_nrow = 0; m_wptr = 0; m_rptr = 0; m_done = 0; m_prev_we = 0;
        #1;
        check1("async rst rd_valid", VW'(rd_valid), '0);
        check1("async rst rd_data", rd_data, '0);
        check1("async rst wr_done", VW'(wr_done), '0);
        wr_en_in = 1'b0; rd_en_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) step(1, 0, 4, rnd_row());
        idle(1);
        for (int i = 0; i < 6; i++) step(0, 1, 4, '0);
        idle(SYS_ROW + 4);

        for (int j = 0; j < SYS_ROW; j++) begin
            tests++;
            if (exp_q[j].size() != 0) begin
                fails++;
                $display("FAIL lane%0d drain got %0d pending want 0", j, exp_q[j].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_mem_buffer.md
Name: input_mem_buffer

Overview:
- Input activation buffer feeding the systolic array.
- Contains SYS_ROW independent per-lane dual-port RAMs and a controller.
- Controller generates write and read addresses and enables for the RAMs.
- A burst of num_row rows is written in, then streamed out row by row (optionally skewed per lane) towards the array's row inputs.

Parameters:
- SYS_ROW, 16, number of lanes (systolic rows); one RAM per lane.
- DATA_WIDTH, 16, bits per lane element.
- ACCUM_ROW, 128, RAM depth in rows; must be ≤ 256.
- ADDR_WIDTH, 8, address counter width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en_in  in  1  level; write burst active while high.
- rd_en_in  in  1  level; read stream active while high.
- num_row  in  32  rows per burst; sampled on wr_en_in rising edge.
- wr_data  in  SYS_ROW*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- rd_data  out  SYS_ROW*DATA_WIDTH  same packing; registered.
- rd_valid  out  SYS_ROW  per-lane valid for rd_data.
- wr_done  out  1  sticky: burst fully written.

Behaviour:
- Reset (async, immediate): clear wr/rd counters, wr_done, rd_valid and rd_data to 0; latched row count to 0. RAM contents are not reset.
- Row count latch: on wr_en_in 0→1 (edge detected against a registered copy), latch num_row clamped to ACCUM_ROW into nrow_q. The same edge also clears wr_done and resets the write counter to 0.
- Write:
  - Each cycle with wr_en_in=1 and wr_ptr < nrow_q, write every lane's wr_data to address wr_ptr, then increment wr_ptr.
  - When wr_ptr reaches nrow_q, stop writing and set wr_done=1 next cycle.
  - If wr_en_in drops early, writing pauses, wr_ptr holds and wr_done stays 0.
  - Re-asserting wr_en_in starts a new burst from address 0.
  - nrow_q=0: no writes; wr_done=1 the cycle after the edge.
- Read:
  - Each cycle with rd_en_in=1 and nrow_q>0, read address rd_ptr from all lanes and increment rd_ptr.
  - rd_ptr wraps to 0 after nrow_q-1, so a continuous rd_en_in streams rows 0..n-1,0..n-1,…
  - rd_data and rd_valid appear 1 cycle after the enable.
  - rd_en_in=0: rd_ptr holds, rd_valid=0, rd_data holds its last value.
  - rd_ptr resets to 0 on wr_en_in rising edge.
- Simultaneous read and write: allowed (separate ports). A read of the address being written that cycle returns old data.
- Reset mid-burst aborts the burst; wr_done=0.

Optional Feature:
- Macro INPUT_MEM_SKEW_EN.
- Defined: lane j's read enable and address pass through a j-stage delay chain, so lane j's rd_data/rd_valid lag lane 0 by j cycles (diagonal wavefront for the systolic array).
  - Lane j first data arrives at cycle j+1 after rd_en_in rises.
  - Delay registers reset to 0.
- Undefined: all lanes aligned, 1-cycle latency, no delay registers.

Decomposition:
- Package input_mem_pkg holds:
  - ADDR_WIDTH and the lane-data typedef (logic [DATA_WIDTH-1:0]).
  - Address typedef addr_t.
  - Clamp helper function for num_row.
- Sub-module input_mem_lane:
  - One lane's ACCUM_ROW×DATA_WIDTH RAM with a synchronous write port and a registered read port.
  - Instantiated SYS_ROW times via generate.
- Controller logic (counters, wr_done, skew chains) lives in the top.

Test Plan:
- Reset, then num_row=8, wr_en_in high 8 cycles, lane data = row index i. Required: wr_done rises the cycle after the 8th write and stays 1.
- Then rd_en_in high 16 cycles (skew off). Required: rd_data all lanes = 0,1,…,7,0,…,7, starting 1 cycle after rd_en_in; rd_valid all-ones throughout.
- num_row=300 with ACCUM_ROW=128. Required: exactly 128 writes; wr_done after 128 cycles; readback wraps at 127→0.
- wr_en_in dropped after 3 of 8 rows, held low 5 cycles. Required: wr_done=0 and wr_ptr held at 3. Re-raise wr_en_in: rewrite starts at address 0, wr_done after 8 more cycles.
- INPUT_MEM_SKEW_EN defined, 8 rows read. Required: lane 0 shows row 0 at cycle 1, lane 15 shows row 0 at cycle 16; each lane outputs 0..7 in order.
- Assert rst mid-read. Required: rd_valid, rd_data and wr_done go to 0 immediately, before the next clock edge.
